// File: rtl/wshb_arbiter.sv
// ---------------------------------------------------------------------------
// wshb_arbiter
//
// Two-master Wishbone classic (ack-terminated) arbiter in front of the single
// SDRAM slave port.
//   M0 : framebuffer reader feeding the video output FIFO (real-time)
//   M1 : pixel writer / pattern generator (best-effort)
//
// The grant is registered. Whoever owns the bus keeps it until it drops cyc.
// Every change of owner, including a master re-acquiring the bus, passes
// through exactly one IDLE cycle with s_cyc low.
//
// Configuration macro:
//   WSHB_ARB_M0_PRIO_EN  defined   : fixed priority, M0 always wins a tie in
//                                    IDLE. The round-robin "last" register
//                                    is not built.
//                        undefined : round-robin tie-break. After reset the
//                                    last owner reads as M1, so M0 wins the
//                                    first tie.
//
// Ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   m0_* / m1_*          master request side (cyc, stb, we, adr, dat_w, sel)
//                        and response side (ack, dat_r)
//   s_*                  slave request side (cyc, stb, we, adr, dat_w, sel)
//                        and response side (ack, dat_r)
//   gnt                  one-hot current owner {M1,M0}; 2'b00 = no owner
// ---------------------------------------------------------------------------
module wshb_arbiter #(
  parameter  int AW = 32,
  parameter  int DW = 32,
  localparam int SW = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,

  // master 0 (video reader)
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_w,
  input  logic [SW-1:0] m0_sel,
  output logic          m0_ack,
  output logic [DW-1:0] m0_dat_r,

  // master 1 (pixel writer)
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_w,
  input  logic [SW-1:0] m1_sel,
  output logic          m1_ack,
  output logic [DW-1:0] m1_dat_r,

  // shared slave port
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_w,
  output logic [SW-1:0] s_sel,
  input  logic          s_ack,
  input  logic [DW-1:0] s_dat_r,

  output logic [1:0]    gnt
);

  // The state encoding is the one-hot grant itself, so gnt comes straight
  // off the state flops: registered, glitch-free, and never 2'b11.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state;
  state_t next_state;
  state_t tie_winner;

  // -------------------------------------------------------------------------
  // Tie-break between two simultaneous requests seen in IDLE
  // -------------------------------------------------------------------------
`ifdef WSHB_ARB_M0_PRIO_EN

  // The video reader must never underrun, so it always wins.
  assign tie_winner = OWN0;

`else

  // Owner of the most recently completed tenure: 0 = M0, 1 = M1.
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of process ordering.
      last <= 1'b1;
    end else if (state == OWN0 && !m0_cyc) begin
      last <= 1'b0;
    end else if (state == OWN1 && !m1_cyc) begin
      last <= 1'b1;
    end
  end

  assign tie_winner = last ? OWN0 : OWN1;

`endif

  // -------------------------------------------------------------------------
  // Grant FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: next_state gets its default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    next_state = state;
    unique case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          next_state = tie_winner;
        end else if (m0_cyc) begin
          next_state = OWN0;
        end else if (m1_cyc) begin
          next_state = OWN1;
        end
      end
      // Dropping cyc always returns to IDLE, even if the same master raises
      // it again at once; that enforces the one-cycle turnaround. It also
      // covers an abort with stb high and no ack: a late s_ack arriving in
      // IDLE is masked below because gnt is 00 by then.
      OWN0: if (!m0_cyc) next_state = IDLE;
      OWN1: if (!m1_cyc) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign gnt = state;

  // -------------------------------------------------------------------------
  // Request mux: each master's signals are gated by its grant bit and the two
  // are OR'ed, so the slave sees all-zero whenever nobody owns the bus. Reset
  // clears the state flops asynchronously, which drops s_cyc immediately.
  // -------------------------------------------------------------------------
  assign s_cyc   = (gnt[0] & m0_cyc) | (gnt[1] & m1_cyc);
  assign s_stb   = (gnt[0] & m0_stb) | (gnt[1] & m1_stb);
  assign s_we    = (gnt[0] & m0_we)  | (gnt[1] & m1_we);
  assign s_adr   = ({AW{gnt[0]}} & m0_adr)   | ({AW{gnt[1]}} & m1_adr);
  assign s_dat_w = ({DW{gnt[0]}} & m0_dat_w) | ({DW{gnt[1]}} & m1_dat_w);
  assign s_sel   = ({SW{gnt[0]}} & m0_sel)   | ({SW{gnt[1]}} & m1_sel);

  // -------------------------------------------------------------------------
  // Response routing: ack goes only to the owner. Read data is broadcast,
  // and each master qualifies it with its own ack.
  // -------------------------------------------------------------------------
  assign m0_ack   = s_ack & gnt[0];
  assign m1_ack   = s_ack & gnt[1];
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

  // -------------------------------------------------------------------------
  // Invariants
  // -------------------------------------------------------------------------
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    gnt != 2'b11);

  a_single_ack : assert property (@(posedge clk) disable iff (!rst_n)
    !(m0_ack && m1_ack));

endmodule

// File: tb/tb_wshb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wshb_arbiter
//
// Directed bench for wshb_arbiter, followed by a randomised two-master run
// against a behavioural SDRAM slave.
//
// Timing: all inputs are driven on the falling edge and outputs are sampled
// on the falling edge (or 1 ns after it). The slave model responds on the
// rising edge.
//
// In the directed tests the bench drives the slave response (man_ack,
// man_dat) by hand. In the random test the behavioural slave takes over,
// inserting 0-3 wait states and holding a 64-word memory; ref_mem is the
// bench's independent copy of that memory, updated from acked writes as the
// masters see them.
// ---------------------------------------------------------------------------
module tb_wshb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int RND_CYCLES = 10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          mcyc [2];
  logic          mstb [2];
  logic          mwe  [2];
  logic [AW-1:0] madr [2];
  logic [DW-1:0] mdw  [2];
  logic [SW-1:0] msel [2];
  logic          mack [2];
  logic [DW-1:0] mdr  [2];

  logic          s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_w, s_dat_r;
  logic [SW-1:0] s_sel;
  logic [1:0]    gnt;

  // slave response sources
  logic          sl_en;
  logic          sl_ack;
  logic [DW-1:0] sl_dat;
  logic          man_ack;
  logic [DW-1:0] man_dat;

  assign s_ack   = sl_ack | man_ack;
  assign s_dat_r = sl_en ? sl_dat : man_dat;

  int total = 0;
  int bad   = 0;
  int n_rd  = 0;

  logic [DW-1:0] ref_mem [64];

  always #5 clk = ~clk;

  wshb_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_cyc   (mcyc[0]),
    .m0_stb   (mstb[0]),
    .m0_we    (mwe[0]),
    .m0_adr   (madr[0]),
    .m0_dat_w (mdw[0]),
    .m0_sel   (msel[0]),
    .m0_ack   (mack[0]),
    .m0_dat_r (mdr[0]),
    .m1_cyc   (mcyc[1]),
    .m1_stb   (mstb[1]),
    .m1_we    (mwe[1]),
    .m1_adr   (madr[1]),
    .m1_dat_w (mdw[1]),
    .m1_sel   (msel[1]),
    .m1_ack   (mack[1]),
    .m1_dat_r (mdr[1]),
    .s_cyc    (s_cyc),
    .s_stb    (s_stb),
    .s_we     (s_we),
    .s_adr    (s_adr),
    .s_dat_w  (s_dat_w),
    .s_sel    (s_sel),
    .s_ack    (s_ack),
    .s_dat_r  (s_dat_r),
    .gnt      (gnt)
  );

  // -------------------------------------------------------------------------
  // Behavioural slave: 64-word memory, 0-3 random wait states per access
  // -------------------------------------------------------------------------
  logic [DW-1:0] mem [64];
  int unsigned   wcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_ack <= 1'b0;
      sl_dat <= '0;
      wcnt   <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h0101_0101;
    end else if (sl_en && s_cyc && s_stb && !sl_ack) begin
      if (wcnt == 0) begin
        sl_ack <= 1'b1;
        if (s_we) mem[s_adr[7:2]] <= s_dat_w;
        else      sl_dat <= mem[s_adr[7:2]];
        wcnt <= $urandom_range(3, 0);
      end else begin
        wcnt <= wcnt - 1;
      end
    end else begin
      sl_ack <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_masters();
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 1'b0; mstb[i] = 1'b0; mwe[i] = 1'b0;
      madr[i] = '0;   mdw[i]  = '0;   msel[i] = '0;
    end
  endtask

  // Enters reset at a falling edge and leaves it at the next one; the FSM
  // sees its first rising edge out of reset half a cycle later.
  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    man_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One tenure in the tie test: owner 'who' must hold the grant, receives 4
  // acks, drops cyc, the bus must go IDLE for one cycle, then 'who' requests
  // again.
  task automatic tie_round(input int who, input string tag);
    int n_own   = 0;
    int n_other = 0;
    check({tag, "_gnt"}, gnt, (who == 0) ? 2'b01 : 2'b10);
    man_ack = 1'b1;
    repeat (4) begin
      #1;
      n_own   += int'(mack[who]);
      n_other += int'(mack[1-who]);
      @(negedge clk);
    end
    man_ack   = 1'b0;
    mcyc[who] = 1'b0;
    mstb[who] = 1'b0;
    check({tag, "_acks"}, n_own, 4);
    check({tag, "_stray"}, n_other, 0);
    @(negedge clk);
    check({tag, "_idle_gnt"}, gnt, 2'b00);
    check({tag, "_idle_cyc"}, s_cyc, 1'b0);
    mcyc[who] = 1'b1;
    mstb[who] = 1'b1;
    @(negedge clk);
  endtask

  task automatic new_req(input int id);
    mstb[id] = 1'b1;
    mwe[id]  = 1'($urandom_range(1, 0));
    madr[id] = {24'h0, 6'($urandom_range(63, 0)), 2'b00};
    mdw[id]  = $urandom;
    msel[id] = 4'hF;
  endtask

  task automatic rand_master(input int id, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (mcyc[id] && mstb[id]) begin
        if (mack[id]) begin
          if (mwe[id]) begin
            ref_mem[madr[id][7:2]] = mdw[id];
          end else begin
            check("rnd_rd_data", mdr[id], ref_mem[madr[id][7:2]]);
            n_rd++;
          end
          mstb[id] = 1'b0;
          case ($urandom_range(3, 0))
            0:       mcyc[id] = 1'b0;
            1:       ;
            default: new_req(id);
          endcase
        end else if ($urandom_range(63, 0) == 0) begin
          mcyc[id] = 1'b0;
          mstb[id] = 1'b0;
        end
      end else if (mcyc[id]) begin
        if ($urandom_range(7, 0) == 0) mcyc[id] = 1'b0;
        else if ($urandom_range(1, 0) == 1) new_req(id);
      end else if ($urandom_range(3, 0) == 0) begin
        mcyc[id] = 1'b1;
        new_req(id);
      end
    end
    mcyc[id] = 1'b0;
    mstb[id] = 1'b0;
  endtask

  task automatic monitor(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("inv_gnt_onehot", gnt == 2'b11, 1'b0);
      check("inv_single_ack", mack[0] & mack[1], 1'b0);
      check("inv_ack_route", (mack[0] & ~gnt[0]) | (mack[1] & ~gnt[1]), 1'b0);
      check("inv_idle_cyc", (gnt == 2'b00) & s_cyc, 1'b0);
    end
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int seq [4];
    int n0;
    int n1;
    int held;

`ifdef WSHB_ARB_M0_PRIO_EN
    seq = '{0, 0, 0, 0};
`else
    seq = '{0, 1, 0, 1};
`endif

    clear_masters();
    sl_en   = 1'b0;
    man_ack = 1'b0;
    man_dat = '0;

    // T1: reset with M0 requesting, then an async reset mid-tenure
    mcyc[0] = 1'b1;
    mstb[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_rst_gnt", gnt, 2'b00);
    check("t1_rst_scyc", s_cyc, 1'b0);
    check("t1_rst_ack", mack[0], 1'b0);
    rst_n = 1'b1;
    #1;
    check("t1_pre_edge_gnt", gnt, 2'b00);
    @(negedge clk);
    check("t1_gnt", gnt, 2'b01);
    check("t1_scyc", s_cyc, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_async_scyc", s_cyc, 1'b0);
    check("t1_async_gnt", gnt, 2'b00);
    clear_masters();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_idle_gnt", gnt, 2'b00);

    // T2: single M1 write
    mcyc[1] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b1;
    madr[1] = 32'h100; mdw[1] = 32'hDEAD_BEEF; msel[1] = 4'hA;
    madr[0] = 32'h5A5A_0000;
    @(negedge clk);
    check("t2_gnt", gnt, 2'b10);
    check("t2_adr", s_adr, 32'h100);
    check("t2_we", s_we, 1'b1);
    check("t2_stb", s_stb, 1'b1);
    check("t2_dat_w", s_dat_w, 32'hDEAD_BEEF);
    check("t2_sel", s_sel, 4'hA);
    check("t2_ack_pre", mack[1], 1'b0);
    man_ack = 1'b1;
    man_dat = 32'h1234_5678;
    #1;
    check("t2_m1_ack", mack[1], 1'b1);
    check("t2_m0_ack", mack[0], 1'b0);
    check("t2_m0_dat_r", mdr[0], 32'h1234_5678);
    check("t2_m1_dat_r", mdr[1], 32'h1234_5678);
    @(negedge clk);
    man_ack = 1'b0;
    mcyc[1] = 1'b0;
    mstb[1] = 1'b0;
    #1;
    check("t2_ack_fall", mack[1], 1'b0);
    @(negedge clk);
    check("t2_idle_gnt", gnt, 2'b00);
    check("t2_idle_adr", s_adr, 32'h0);
    check("t2_idle_we", s_we, 1'b0);
    man_ack = 1'b1;
    #1;
    check("t2_idle_glitch", {mack[1], mack[0]}, 2'b00);
    man_ack = 1'b0;

    // T3: both masters request from reset, each re-requests after 4 acks
    clear_masters();
    mcyc[0] = 1'b1; mstb[0] = 1'b1;
    mcyc[1] = 1'b1; mstb[1] = 1'b1;
    do_reset();
    @(negedge clk);
    for (int r = 0; r < 4; r++) tie_round(seq[r], $sformatf("t3_r%0d", r));

    // T4: 16-ack M0 burst while M1 waits
    clear_masters();
    madr[0] = 32'h300;
    madr[1] = 32'h200;
    mcyc[0] = 1'b1; mstb[0] = 1'b1;
    do_reset();
    @(negedge clk);
    check("t4_gnt0", gnt, 2'b01);
    mcyc[1] = 1'b1; mstb[1] = 1'b1;
    man_ack = 1'b1;
    n0 = 0; n1 = 0; held = 0;
    repeat (16) begin
      #1;
      n0   += int'(mack[0]);
      n1   += int'(mack[1]);
      held += int'(gnt == 2'b01);
      @(negedge clk);
    end
    check("t4_m0_acks", n0, 16);
    check("t4_m1_acks", n1, 0);
    check("t4_held", held, 16);
    check("t4_adr_burst", s_adr, 32'h300);
    man_ack = 1'b0;
    mcyc[0] = 1'b0;
    mstb[0] = 1'b0;
    @(negedge clk);
    check("t4_turn_idle", gnt, 2'b00);
    @(negedge clk);
    check("t4_gnt1", gnt, 2'b10);
    check("t4_adr1", s_adr, 32'h200);

    // T5: M1 aborts before its ack; a late ack arrives in IDLE
    mcyc[1] = 1'b0;
    mstb[1] = 1'b0;
    @(negedge clk);
    check("t5_idle_gnt", gnt, 2'b00);
    check("t5_idle_cyc", s_cyc, 1'b0);
    man_ack = 1'b1;
    mcyc[0] = 1'b1; mstb[0] = 1'b1;
    mcyc[1] = 1'b1; mstb[1] = 1'b1;
    #1;
    check("t5_late_ack", {mack[1], mack[0]}, 2'b00);
    @(negedge clk);
    man_ack = 1'b0;
    check("t5_next_gnt", gnt, 2'b01);
    #1;
    check("t5_no_ack", {mack[1], mack[0]}, 2'b00);

    // T6: random traffic against the behavioural slave
    clear_masters();
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i) * 32'h0101_0101;
    sl_en = 1'b1;
    fork
      rand_master(0, RND_CYCLES);
      rand_master(1, RND_CYCLES);
      monitor(RND_CYCLES);
    join
    check("t6_reads_seen", n_rd > 50, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
